// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq - multi-cycle integer ALU for the execute stage.
//
// Accepts one operation per valid/ready handshake and returns the result,
// zero flag, memory-access flags and register-write intent through a second
// valid/ready handshake. Single-cycle operations complete on the accept
// edge. MUL (shift-add) and DIVU/REMU (restoring division) iterate one bit
// per clock for WIDTH clocks.
//
// Parameters
//   WIDTH      operand/result width (power of two, >= 4)
//   SHAMT_W    number of low bits of b used as a shift amount
//   MULDIV_EN  1: opcodes 13..15 are MUL/DIVU/REMU, 0: they are illegal
//
// Ports
//   clk, rst_n               rising-edge clock, async active-low reset
//   in_valid / in_ready      request handshake (in_ready is combinational
//                            on out_ready while a result is held)
//   a, b, alu_control        operands and opcode, captured at accept
//   out_valid / out_ready    result handshake
//   result, zero             registered result and result == 0
//   mem_read, mem_write      LW / SW in flight at the output
//   reg_write                result must be written to rd
//   illegal                  opcode 0, or 13..15 with MULDIV_EN = 0
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = $clog2(WIDTH),
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             illegal
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_ILLEGAL = 4'd0,
      OP_ADD     = 4'd1,
      OP_SUB     = 4'd2,
      OP_XOR     = 4'd3,
      OP_OR      = 4'd4,
      OP_AND     = 4'd5,
      OP_SLL     = 4'd6,
      OP_SRL     = 4'd7,
      OP_SRA     = 4'd8,
      OP_SLT     = 4'd9,
      OP_SLTU    = 4'd10,
      OP_LW      = 4'd11,
      OP_SW      = 4'd12,
      OP_MUL     = 4'd13,
      OP_DIVU    = 4'd14,
      OP_REMU    = 4'd15
   } op_e;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_e             state_q,     state_d;
   op_e                op_q,        op_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   // Iteration registers, shared by multiply and divide:
   //   MUL : acc = partial product, opa = multiplicand (<<1), opb = multiplier (>>1)
   //   DIV : acc = partial remainder, opa = dividend shifting out / quotient
   //         shifting in, opb = divisor (constant)
   logic [WIDTH-1:0]   acc_q,       acc_d;
   logic [WIDTH-1:0]   opa_q,       opa_d;
   logic [WIDTH-1:0]   opb_q,       opb_d;
   // Registered outputs
   logic [WIDTH-1:0]   result_q,    result_d;
   logic               mem_read_q,  mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic               reg_write_q, reg_write_d;
   logic               illegal_q,   illegal_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic accept;
   logic consume;

   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // ------------------------------------------------------------------------
   // Single-cycle datapath, evaluated directly on the incoming operands so
   // the result can be registered on the accept edge.
   // ------------------------------------------------------------------------
   op_e                op_in;
   logic               is_iter;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   sc_result;
   logic               sc_mem_read;
   logic               sc_mem_write;
   logic               sc_reg_write;
   logic               sc_illegal;

   assign op_in   = op_e'(alu_control);
   assign shamt   = b[SHAMT_W-1:0];
   assign is_iter = MULDIV_EN && (alu_control >= 4'd13);

   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first;
      // a path that leaves one unassigned would infer a latch.
      sc_result    = '0;
      sc_mem_read  = 1'b0;
      sc_mem_write = 1'b0;
      sc_reg_write = 1'b1;
      sc_illegal   = 1'b0;
      case (op_in)
         OP_ADD:  sc_result = a + b;
         OP_SUB:  sc_result = a - b;
         OP_XOR:  sc_result = a ^ b;
         OP_OR:   sc_result = a | b;
         OP_AND:  sc_result = a & b;
         OP_SLL:  sc_result = a << shamt;
         OP_SRL:  sc_result = a >> shamt;
         OP_SRA:  sc_result = $signed(a) >>> shamt;
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_LW: begin
            sc_result   = a + b;
            sc_mem_read = 1'b1;
         end
         OP_SW: begin
            sc_result    = a + b;
            sc_mem_write = 1'b1;
            sc_reg_write = 1'b0;
         end
         OP_MUL, OP_DIVU, OP_REMU: begin
            // Only reached here as a single-cycle op when the iterative
            // unit is compiled out; then these codes are illegal.
            if (!MULDIV_EN) begin
               sc_reg_write = 1'b0;
               sc_illegal   = 1'b1;
            end
         end
         default: begin
            sc_reg_write = 1'b0;
            sc_illegal   = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // One iteration of shift-add multiply or restoring divide.
   // ------------------------------------------------------------------------
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]   step_opa;
   logic [WIDTH-1:0]   step_opb;
   logic [WIDTH-1:0]   iter_result;

   // The remainder is always below the divisor, so the shifted remainder
   // fits in WIDTH+1 bits and the trial subtraction's top bit is its sign.
   assign rem_shift = {acc_q, opa_q[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, opb_q};

   always_comb begin
      step_acc = acc_q;
      step_opa = opa_q;
      step_opb = opb_q;
      if (op_q == OP_MUL) begin
         step_acc = acc_q + (opb_q[0] ? opa_q : '0);
         step_opa = opa_q << 1;
         step_opb = opb_q >> 1;
      end else if (!trial[WIDTH]) begin
         // Subtraction fits: keep it and shift in a quotient 1. A zero
         // divisor always lands here, giving all-ones quotient and a
         // remainder equal to the dividend.
         step_acc = trial[WIDTH-1:0];
         step_opa = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
         step_acc = rem_shift[WIDTH-1:0];
         step_opa = {opa_q[WIDTH-2:0], 1'b0};
      end
   end

   assign iter_result = (op_q == OP_DIVU) ? step_opa : step_acc;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      result_d    = result_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      reg_write_d = reg_write_q;
      illegal_d   = illegal_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               op_d = op_in;
               if (is_iter) begin
                  // Multiply and divide load identically: a into the
                  // shifting register, b as multiplier/divisor.
                  state_d = ST_BUSY;
                  cnt_d   = CNT_W'(WIDTH);
                  acc_d   = '0;
                  opa_d   = a;
                  opb_d   = b;
               end else begin
                  state_d     = ST_DONE;
                  result_d    = sc_result;
                  mem_read_d  = sc_mem_read;
                  mem_write_d = sc_mem_write;
                  reg_write_d = sc_reg_write;
                  illegal_d   = sc_illegal;
               end
            end else if (consume) begin
               state_d = ST_IDLE;
            end
         end

         ST_BUSY: begin
            acc_d = step_acc;
            opa_d = step_opa;
            opb_d = step_opb;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d     = ST_DONE;
               result_d    = iter_result;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               reg_write_d = 1'b1;
               illegal_d   = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the iteration registers are reset along with the state so
         // an interrupted multiply/divide leaves no residue behind; they
         // are reloaded on every accept anyway.
         state_q     <= ST_IDLE;
         op_q        <= OP_ILLEGAL;
         cnt_q       <= '0;
         acc_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every flop samples the
         // _d values from before this edge regardless of statement order.
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         result_q    <= result_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         reg_write_q <= reg_write_d;
         illegal_q   <= illegal_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign reg_write = reg_write_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq - directed self-checking bench for alu_seq (WIDTH = 32).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// there too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_control;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         mem_read;
   logic         mem_write;
   logic         reg_write;
   logic         illegal;

   int checks   = 0;
   int failures = 0;

   alu_seq #(
      .WIDTH     (W),
      .MULDIV_EN (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Present one request for one clock; returns 1 unit after the accept edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
      in_valid    = 1'b1;
      alu_control = op;
      a           = aa;
      b           = bb;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count cycles from the accept cycle until out_valid is seen (accept
   // edge counts as 1). Also note whether in_ready rose while waiting.
   task automatic wait_valid(input int budget, output int cycles, output bit ready_seen);
      cycles     = 1;
      ready_seen = 1'b0;
      while (!out_valid && cycles < budget) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic exec(input string tag, input logic [3:0] op, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] exp_res, input int exp_lat);
      int cyc;
      bit rdy;
      send(op, aa, bb);
      wait_valid(100, cyc, rdy);
      check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_res"}, result, exp_res);
      if (exp_lat > 1) check({tag, "_busy_rdy"}, 32'(rdy), 32'd0);
   endtask

   initial begin
      bit seen;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      alu_control = 4'd0;
      out_ready   = 1'b1;
      #12;
      check("rst_result", result, 32'h0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_flags", {28'd0, mem_read, mem_write, reg_write, illegal}, 32'h0);
      check("rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD wrap to zero
      exec("add", 4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
      check("add_zero", 32'(zero), 32'd1);
      check("add_regw", 32'(reg_write), 32'd1);

      // Back-to-back SUB, SLT, SLTU: one result per cycle
      in_valid = 1'b1; alu_control = 4'd2; a = 32'd5; b = 32'd7;
      @(posedge clk); #1;
      check("b2b_sub_v", 32'(out_valid), 32'd1);
      check("b2b_sub", result, 32'hFFFF_FFFE);
      alu_control = 4'd9; a = 32'hFFFF_FFFE; b = 32'h1;
      @(posedge clk); #1;
      check("b2b_slt_v", 32'(out_valid), 32'd1);
      check("b2b_slt", result, 32'h1);
      alu_control = 4'd10;
      @(posedge clk); #1;
      check("b2b_sltu_v", 32'(out_valid), 32'd1);
      check("b2b_sltu", result, 32'h0);
      check("b2b_sltu_z", 32'(zero), 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b_drain", 32'(out_valid), 32'd0);

      // Shifts use only the low 5 bits of b
      exec("sra", 4'd8, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
      exec("sll", 4'd6, 32'h8000_0000, 32'h24, 32'h0, 1);
      exec("srl", 4'd7, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
      exec("xor", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
      exec("and", 4'd5, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);

      // Illegal opcode
      exec("ill", 4'd0, 32'h5, 32'h6, 32'h0, 1);
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_regw", 32'(reg_write), 32'd0);

      // Iterative ops: WIDTH+1 = 33 cycle latency
      exec("mul", 4'd13, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 33);
      check("mul_regw", 32'(reg_write), 32'd1);
      check("mul_ill", 32'(illegal), 32'd0);
      exec("divu", 4'd14, 32'd100, 32'd7, 32'd14, 33);
      exec("remu", 4'd15, 32'd100, 32'd7, 32'd2, 33);
      exec("divu0", 4'd14, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
      exec("remu0", 4'd15, 32'd9, 32'd0, 32'd9, 33);

      // SW held with out_ready low
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(4'd12, 32'h1000, 32'h10);
      for (int i = 0; i < 4; i++) begin
         check("sw_valid", 32'(out_valid), 32'd1);
         check("sw_res", result, 32'h1010);
         check("sw_flags", {28'd0, mem_read, mem_write, reg_write, illegal}, 32'h4);
         check("sw_rdy", 32'(in_ready), 32'd0);
         if (i < 3) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      #1;
      check("sw_rdy_comb", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("sw_consumed", 32'(out_valid), 32'd0);

      // LW
      exec("lw", 4'd11, 32'h2000, 32'h4, 32'h2004, 1);
      check("lw_flags", {28'd0, mem_read, mem_write, reg_write, illegal}, 32'ha);

      // Reset in the middle of a multiply
      send(4'd13, 32'd3, 32'd5);
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_res", result, 32'h0);
      check("mid_rst_zero", 32'(zero), 32'd1);
      check("mid_rst_flags", {28'd0, mem_read, mem_write, reg_write, illegal}, 32'h0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("mid_no_result", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle integer ALU in the execute stage.
- Operand width is generic. Adds a valid/ready handshake on both input and output, plus optional iterative multiply and unsigned divide/remainder.
- Sits between decode/operand-fetch and writeback/memory. Carries result, zero flag, memory-access flags and register-write intent to the next stage.

Parameters:
- WIDTH, 32, operand and result width in bits; any value ≥4 and a power of two.
- SHAMT_W, $clog2(WIDTH), number of low bits of b used as shift amount.
- MULDIV_EN, 1, enables MUL/DIVU/REMU; when 0 those codes behave as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_control  in  4  opcode: 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 LW, 12 SW, 13 MUL, 14 DIVU, 15 REMU; 0 illegal
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result, also memory address for LW/SW
- zero  out  1  result == 0
- mem_read  out  1  LW in flight at output
- mem_write  out  1  SW in flight at output
- reg_write  out  1  result must be written to rd
- illegal  out  1  opcode 0, or 13–15 with MULDIV_EN=0

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - result=0, zero=1.
  - out_valid, mem_read, mem_write, reg_write, illegal = 0.
  - Any iteration in progress is discarded; no output is produced for it.
- States: IDLE, BUSY (iterative op), DONE (output held).
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational on out_ready.
  - A request is accepted on a rising edge with in_valid & in_ready.
  - A result is consumed on a rising edge with out_valid & out_ready.
- Outputs are registered and stay stable while out_valid & !out_ready.
- Single-cycle ops (1–12, illegal): accept edge → DONE. out_valid is visible the next cycle (latency 1).
- Iterative ops (13–15): accept edge → BUSY with counter = WIDTH.
  - One iteration per edge.
  - After the WIDTH-th iteration edge → DONE. out_valid is seen WIDTH+1 cycles after accept.
- DONE transitions:
  - consumed with no new accept → IDLE.
  - consumed together with a new accept → DONE for a single-cycle op, or BUSY for an iterative op.
  - Back-to-back single-cycle ops therefore give 1 result per cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shifts use b[SHAMT_W-1:0] only. SRA replicates a[WIDTH-1].
  - SLT is a signed compare; SLTU is an unsigned compare. Result is 1 or 0, zero-extended.
  - MUL returns the low WIDTH bits of a*b, computed by iterative shift-add.
  - DIVU/REMU use restoring division.
  - Divide by zero: DIVU = all ones, REMU = a. Still takes the full WIDTH iterations.
- Side-band flags:
  - LW: result=a+b, mem_read=1, reg_write=1.
  - SW: result=a+b, mem_write=1, reg_write=0.
  - Ops 1–10 and 13–15: reg_write=1, mem flags 0.
  - Illegal: result=0, illegal=1, reg_write=0, mem flags 0.
- zero is computed from the registered result and is valid with out_valid.
- Operands and opcode are captured at accept. Input changes during BUSY have no effect.
- in_valid while BUSY is ignored (in_ready=0). The requester must hold the request.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=1, out_ready=1 → next cycle: out_valid=1, result=0, zero=1, reg_write=1.
- Back-to-back SUB 5−7 then SLT a=0xFFFFFFFE, b=1, then SLTU on the same operands, out_ready=1 → three consecutive valid cycles with results 0xFFFFFFFE, 1, 0.
- SRA a=0x80000000, b=0x00000024 (amount 4) → result 0xF8000000. SLL with the same operands → 0.
- MUL a=0x00012345, b=0x00010000 → out_valid exactly 33 cycles after accept, result 0x23450000. in_ready stays 0 throughout BUSY.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 9/0 → 0xFFFFFFFF. REMU 9/0 → 9.
- SW a=0x1000, b=0x10 with out_ready=0 for 3 cycles → result 0x1010, mem_write=1, reg_write=0 held stable. Assert rst_n=0 mid-MUL → all outputs return to reset values immediately, and no result follows.
